// File: rtl/player_fsm_v2.sv
// Per-player fighter controller: frame-ticked movement/attack/stun FSM with health and KO.
// Optional build macro PLAYER_CHIP_DAMAGE_EN: blocking costs DMG>>2 health, never below 1.
module player_fsm_v2 #(
  parameter int SIDE      = 0,
  parameter int XW        = 10,
  parameter int X_START_L = 210,
  parameter int X_START_R = 420,
  parameter int X_MIN     = 50,
  parameter int X_MAX     = 490,
  parameter int SPD_FWD   = 3,
  parameter int SPD_BACK  = 2,
  parameter int STARTUP   = 5,
  parameter int ACTIVE    = 2,
  parameter int RECOVERY  = 16,
  parameter int HS_B      = 15,
  parameter int HS_D      = 14,
  parameter int BS_B      = 13,
  parameter int BS_D      = 12,
  parameter int HP_MAX    = 100,
  parameter int HPW       = 7,
  parameter int DMG_B     = 10,
  parameter int DMG_D     = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           left,
  input  logic           right,
  input  logic           attack,
  input  logic [1:0]     hit,
  output logic [XW-1:0]  posx,
  output logic [3:0]     state,
  output logic           atk_active,
  output logic           atk_dir,
  output logic [HPW-1:0] health,
  output logic           ko
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FWD       = 4'd1,
    S_BACK      = 4'd2,
    S_B_START   = 4'd3,
    S_B_ACTIVE  = 4'd4,
    S_B_RECOV   = 4'd5,
    S_D_START   = 4'd6,
    S_D_ACTIVE  = 4'd7,
    S_D_RECOV   = 4'd8,
    S_HITSTUN   = 4'd9,
    S_BLOCKSTUN = 4'd10,
    S_KO        = 4'd11
  } state_t;

  localparam bit             SIDE_R    = (SIDE != 0);
  localparam logic [XW-1:0]  X_RST     = SIDE_R ? XW'(X_START_R) : XW'(X_START_L);
  localparam logic [XW:0]    XMIN_W    = (XW+1)'(X_MIN);
  localparam logic [XW:0]    XMAX_W    = (XW+1)'(X_MAX);
  localparam logic [XW:0]    SPDF_W    = (XW+1)'(SPD_FWD);
  localparam logic [XW:0]    SPDB_W    = (XW+1)'(SPD_BACK);
  localparam logic [4:0]     LD_START  = 5'(STARTUP - 1);
  localparam logic [4:0]     LD_ACTIVE = 5'(ACTIVE - 1);
  localparam logic [4:0]     LD_RECOV  = 5'(RECOVERY - 1);
  localparam logic [4:0]     LD_HS_B   = 5'(HS_B - 1);
  localparam logic [4:0]     LD_HS_D   = 5'(HS_D - 1);
  localparam logic [4:0]     LD_BS_B   = 5'(BS_B - 1);
  localparam logic [4:0]     LD_BS_D   = 5'(BS_D - 1);
  localparam logic [HPW-1:0] HP_RST    = HPW'(HP_MAX);
  localparam logic [HPW-1:0] DMG_B_W   = HPW'(DMG_B);
  localparam logic [HPW-1:0] DMG_D_W   = HPW'(DMG_D);

  state_t         state_q, state_d, atk_tgt;
  logic [4:0]     fcnt_q, fcnt_d;
  logic [XW-1:0]  posx_q, posx_d;
  logic [HPW-1:0] health_q, health_d, dmg;
  logic           atk_active_q, atk_active_d;
  logic           atk_dir_q, atk_dir_d;
  logic           ko_q, ko_d;
  logic           toward, away, hit_dir, free_dec, move_up;
  logic [XW:0]    pos_ext, step, pos_mv;
`ifdef PLAYER_CHIP_DAMAGE_EN
  logic [HPW-1:0] chip;
`endif

  function automatic state_t free_next(input logic atk, input logic tow, input logic aw,
                                       input state_t tgt);
    if (atk)      return tgt;
    else if (tow) return S_FWD;
    else if (aw)  return S_BACK;
    else          return S_IDLE;
  endfunction

  // Both directions pressed counts as "away" (defensive by default).
  assign toward  = (SIDE_R ? left : right) & ~(left & right);
  assign away    = (left | right) & ~toward;
  assign hit_dir = hit[1];

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    posx_d   = posx_q;
    health_d = health_q;
    free_dec = 1'b0;
    atk_tgt  = S_B_START;
    dmg      = hit_dir ? DMG_D_W : DMG_B_W;
`ifdef PLAYER_CHIP_DAMAGE_EN
    chip     = dmg >> 2;
`endif
    if (tick) begin
      if (state_q == S_KO) begin
        state_d = S_KO;
      end else if ((hit != 2'b00) && (state_q != S_HITSTUN) && (state_q != S_BLOCKSTUN)) begin
        if (state_q == S_BACK) begin
          state_d = S_BLOCKSTUN;
          fcnt_d  = hit_dir ? LD_BS_D : LD_BS_B;
`ifdef PLAYER_CHIP_DAMAGE_EN
          health_d = (health_q > chip) ? health_q - chip : HPW'(1);
`endif
        end else if (health_q > dmg) begin
          state_d  = S_HITSTUN;
          fcnt_d   = hit_dir ? LD_HS_D : LD_HS_B;
          health_d = health_q - dmg;
        end else begin
          state_d  = S_KO;
          fcnt_d   = '0;
          health_d = '0;
        end
      end else begin
        case (state_q)
          S_IDLE: free_dec = 1'b1;
          S_FWD, S_BACK: begin
            free_dec = 1'b1;
            atk_tgt  = S_D_START;
          end
          S_B_START, S_D_START: begin
            if (fcnt_q == '0) begin
              state_d = (state_q == S_B_START) ? S_B_ACTIVE : S_D_ACTIVE;
              fcnt_d  = LD_ACTIVE;
            end else fcnt_d = fcnt_q - 5'd1;
          end
          S_B_ACTIVE, S_D_ACTIVE: begin
            if (fcnt_q == '0) begin
              state_d = (state_q == S_B_ACTIVE) ? S_B_RECOV : S_D_RECOV;
              fcnt_d  = LD_RECOV;
            end else fcnt_d = fcnt_q - 5'd1;
          end
          S_B_RECOV, S_D_RECOV, S_HITSTUN, S_BLOCKSTUN: begin
            if (fcnt_q == '0) begin
              free_dec = 1'b1;
              atk_tgt  = (state_q == S_D_RECOV) ? S_D_START : S_B_START;
            end else fcnt_d = fcnt_q - 5'd1;
          end
          default: begin
            state_d = S_IDLE;
            fcnt_d  = '0;
          end
        endcase
        if (free_dec) begin
          state_d = free_next(attack, toward, away, atk_tgt);
          fcnt_d  = (state_d == S_B_START || state_d == S_D_START) ? LD_START : '0;
        end
      end
    end

    // Move at XW+1 bits so a step below zero clamps instead of wrapping.
    pos_ext = {1'b0, posx_q};
    step    = (state_d == S_FWD) ? SPDF_W : SPDB_W;
    move_up = (state_d == S_FWD) ^ SIDE_R;
    pos_mv  = pos_ext;
    if (tick && (state_d == S_FWD || state_d == S_BACK)) begin
      if (move_up)              pos_mv = pos_ext + step;
      else if (pos_ext < step)  pos_mv = '0;
      else                      pos_mv = pos_ext - step;
      if (pos_mv < XMIN_W)      pos_mv = XMIN_W;
      else if (pos_mv > XMAX_W) pos_mv = XMAX_W;
      posx_d = pos_mv[XW-1:0];
    end

    atk_active_d = (state_d == S_B_ACTIVE) || (state_d == S_D_ACTIVE);
    atk_dir_d    = (state_d == S_D_START) || (state_d == S_D_ACTIVE) || (state_d == S_D_RECOV);
    ko_d         = (state_d == S_KO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      fcnt_q       <= '0;
      posx_q       <= X_RST;
      health_q     <= HP_RST;
      atk_active_q <= 1'b0;
      atk_dir_q    <= 1'b0;
      ko_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      posx_q       <= posx_d;
      health_q     <= health_d;
      atk_active_q <= atk_active_d;
      atk_dir_q    <= atk_dir_d;
      ko_q         <= ko_d;
    end
  end

  assign posx       = posx_q;
  assign state      = state_q;
  assign atk_active = atk_active_q;
  assign atk_dir    = atk_dir_q;
  assign health     = health_q;
  assign ko         = ko_q;

endmodule

// File: doc/player_fsm_v2.md
# player_fsm_v2

Parametrised fighter controller for one player: a frame-ticked state machine covering movement, basic and directional attacks, hitstun, blockstun, health and knockout. It sits between the input synchroniser and the collision/render logic, one instance per side. It replaces the free-running-counter player FSM with per-state frame down-counters, configurable frame data, clamped movement, health tracking and a terminal KO state.

## Interface
- SIDE, 0, 0 = left player (forward is +x), 1 = right player (forward is −x)
- XW, 10, position width
- X_START_L / X_START_R, 210 / 420, reset posx for SIDE 0 / 1
- X_MIN / X_MAX, 50 / 490, inclusive posx clamp limits
- SPD_FWD / SPD_BACK, 3 / 2, pixels per tick when moving forward / back
- STARTUP / ACTIVE / RECOVERY, 5 / 2 / 16, attack phase lengths in ticks (each ≥1, ≤31)
- HS_B / HS_D, 15 / 14, hitstun ticks when hit by basic / directional
- BS_B / BS_D, 13 / 12, blockstun ticks when blocking basic / directional
- HP_MAX, 100, reset health; HPW, 7, health width
- DMG_B / DMG_D, 10 / 15, damage for basic / directional hits

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle frame strobe; all state, counter, position and health updates happen only on cycles with tick=1
- left, right, attack  in  1 each  synchronised player controls
- hit  in  2  00 none, 01 basic, 10 directional, 11 treated as directional
- posx  out  XW  current x position
- state  out  4  current state encoding
- atk_active  out  1  high in B_ACTIVE or D_ACTIVE
- atk_dir  out  1  high in D_START, D_ACTIVE, D_RECOV
- health  out  HPW  remaining health
- ko  out  1  high in KO

## Operation
- States: IDLE=0, FWD=1, BACK=2, B_START=3, B_ACTIVE=4, B_RECOV=5, D_START=6, D_ACTIVE=7, D_RECOV=8, HITSTUN=9, BLOCKSTUN=10, KO=11; 12–15 recover to IDLE on next tick.
- 5-bit frame counter fcnt loaded with (duration−1) on entry to every timed state; decremented each tick; timed state exits on a tick where fcnt==0, so each lasts exactly its duration in ticks.
- Direction decode: toward = (SIDE?left:right) & ~(left&right); away = otherwise any direction pressed; both pressed = away.
- Free decode (IDLE, FWD, BACK, and exit of B_RECOV/D_RECOV/HITSTUN/BLOCKSTUN): attack → B_START from IDLE/stun/B_RECOV exit, D_START from FWD/BACK/D_RECOV exit; else toward → FWD; away → BACK; else IDLE.
- Phase order: x_START (STARTUP) → x_ACTIVE (ACTIVE) → x_RECOV (RECOVERY) → free decode.
- Hit handling on a tick with hit≠00, any state except HITSTUN, BLOCKSTUN, KO: in BACK → BLOCKSTUN (BS_B/BS_D), no damage; elsewhere → HITSTUN (HS_B/HS_D), health −= DMG_B/DMG_D. Hits during HITSTUN/BLOCKSTUN are ignored.
- Health subtraction saturates at 0; if the result is 0 the next state is KO instead of HITSTUN.
- KO is terminal until reset: inputs and hits ignored, posx frozen, atk_active=0.
- Movement: on a tick whose next state is FWD/BACK, posx moves by SPD_FWD/SPD_BACK in the side-dependent direction; result clamped to [X_MIN, X_MAX] before registering; computed at XW+1 bits so underflow never wraps.

## Timing
- Reset (rst=0, async): state=IDLE, fcnt=0, posx=X_START_L/X_START_R, health=HP_MAX, atk_active=0, atk_dir=0, ko=0. Reset mid-attack or mid-stun discards all progress.
- All outputs registered; changes appear the cycle after the tick that causes them. Non-tick cycles hold everything.
- Simultaneous hit and attack/direction on the same tick: hit wins.
- Hit on the tick that would end an attack phase: hit wins.

## Configuration
- PLAYER_CHIP_DAMAGE_EN defined: blocking costs chip damage DMG>>2 (saturating); chip damage alone cannot reduce health below 1 (no KO from block). Undefined: blocking costs no health.

## Test plan
- Reset SIDE=0, hold right 10 ticks → posx 210→240, state FWD; release → IDLE next tick.
- SIDE=1, hold right from posx 488 → posx 490 after one tick, stays 490 (clamp, no wrap).
- IDLE, pulse attack → B_START 5 ticks, B_ACTIVE 2 ticks (atk_active=1), B_RECOV 16 ticks, then IDLE.
- BACK, hit=01 → BLOCKSTUN 13 ticks, health 100 (100→98 with PLAYER_CHIP_DAMAGE_EN); IDLE, hit=10 → HITSTUN 14 ticks, health 85.
- Ten basic hits spaced by stun → health 0, state KO, ko=1; further inputs ignored; rst=0 restores health 100, IDLE.
- Assert rst=0 mid-D_ACTIVE → state IDLE, atk_active=0, atk_dir=0 immediately (async).
